// File: rtl/adder_tree_stream.sv
// adder_tree_stream: pipelined adder tree summing N=2**(LAYER_NUM-1) lanes with valid/ready flow control
// Ports: clk, rst_n (async active-low); din_valid/din_ready/adder_din (N lanes of MIN_ADDER_WIDTH);
//        dout_valid/dout_ready/adder_dout (LAYER_NUM+MIN_ADDER_WIDTH bits, 0 when not valid).
// Option: define ADDER_TREE_ACC_EN to add din_last and a frame accumulator after the tree.
module adder_tree_stream #(
  parameter int LAYER_NUM       = 4,
  parameter int MIN_ADDER_WIDTH = 8,
  parameter int SIGNED          = 0
) (
  input  logic                                           clk,
  input  logic                                           rst_n,
`ifdef ADDER_TREE_ACC_EN
  input  logic                                           din_last,
`endif
  input  logic                                           din_valid,
  output logic                                           din_ready,
  input  logic [(2**(LAYER_NUM-1))*MIN_ADDER_WIDTH-1:0]  adder_din,
  output logic                                           dout_valid,
  input  logic                                           dout_ready,
  output logic [LAYER_NUM+MIN_ADDER_WIDTH-1:0]           adder_dout
);
  localparam int N  = 2**(LAYER_NUM-1);
  localparam int MW = MIN_ADDER_WIDTH;
  localparam int OW = LAYER_NUM+MIN_ADDER_WIDTH;
  logic                 en;
  logic [LAYER_NUM-1:0] v;
  logic [OW-1:0]        sum_x;
  assign en        = !dout_valid || dout_ready;
  assign din_ready = en;
  // layer 0 registers the raw lanes; layer k holds N>>k partial sums of width MW+k
  for (genvar k = 0; k < LAYER_NUM; k++) begin : g
    logic [MW+k-1:0] d [N>>k];
    if (k == 0) begin : in_l
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) for (int j = 0; j < N; j++) d[j] <= '0;
        else if (en) for (int j = 0; j < N; j++) d[j] <= adder_din[j*MW +: MW];
    end else begin : add_l
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) for (int j = 0; j < (N>>k); j++) d[j] <= '0;
        else if (en)
          for (int j = 0; j < (N>>k); j++)
            d[j] <= {(SIGNED != 0) && g[k-1].d[2*j][MW+k-2], g[k-1].d[2*j]}
                  + {(SIGNED != 0) && g[k-1].d[2*j+1][MW+k-2], g[k-1].d[2*j+1]};
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) v <= '0;
    else if (en) v <= {v[LAYER_NUM-2:0], din_valid};
  assign sum_x = {(SIGNED != 0) && g[LAYER_NUM-1].d[0][MW+LAYER_NUM-2], g[LAYER_NUM-1].d[0]};
`ifdef ADDER_TREE_ACC_EN
  logic [LAYER_NUM-1:0] lst;
  logic [OW-1:0]        acc, res;
  logic                 rv;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) lst <= '0;
    else if (en) lst <= {lst[LAYER_NUM-2:0], din_last};
  // a beat tagged last publishes the running total and restarts the frame at 0
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      acc <= '0;
      res <= '0;
      rv  <= 1'b0;
    end else if (en) begin
      rv <= v[LAYER_NUM-1] && lst[LAYER_NUM-1];
      if (v[LAYER_NUM-1] && lst[LAYER_NUM-1]) begin
        res <= acc + sum_x;
        acc <= '0;
      end else if (v[LAYER_NUM-1]) acc <= acc + sum_x;
    end
  assign dout_valid = rv;
  assign adder_dout = rv ? res : '0;
`else
  assign dout_valid = v[LAYER_NUM-1];
  assign adder_dout = v[LAYER_NUM-1] ? sum_x : '0;
`endif
endmodule

// File: tb/tb_adder_tree_stream.sv
// tb_adder_tree_stream: directed and random checks of adder_tree_stream (unsigned and signed instances)
module tb_adder_tree_stream;
  localparam int L  = 4;
  localparam int W  = 8;
  localparam int N  = 8;
  localparam int OW = 12;
  logic clk = 0, rst_n = 0, din_valid = 0, dout_ready = 1, din_last = 0;
  logic [N*W-1:0] adder_din = '0;
  logic din_ready_u, dout_valid_u, din_ready_s, dout_valid_s;
  logic [OW-1:0] dout_u, dout_s;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  adder_tree_stream #(.LAYER_NUM(L), .MIN_ADDER_WIDTH(W), .SIGNED(0)) dut_u (
    .clk(clk), .rst_n(rst_n),
`ifdef ADDER_TREE_ACC_EN
    .din_last(din_last),
`endif
    .din_valid(din_valid), .din_ready(din_ready_u), .adder_din(adder_din),
    .dout_valid(dout_valid_u), .dout_ready(dout_ready), .adder_dout(dout_u));
  adder_tree_stream #(.LAYER_NUM(L), .MIN_ADDER_WIDTH(W), .SIGNED(1)) dut_s (
    .clk(clk), .rst_n(rst_n),
`ifdef ADDER_TREE_ACC_EN
    .din_last(din_last),
`endif
    .din_valid(din_valid), .din_ready(din_ready_s), .adder_din(adder_din),
    .dout_valid(dout_valid_s), .dout_ready(dout_ready), .adder_dout(dout_s));
  function automatic logic [OW-1:0] ref_sum(input logic [N*W-1:0] d, input bit sgn);
    int s = 0;
    for (int i = 0; i < N; i++) begin
      logic [W-1:0] x;
      x = d[i*W +: W];
      s += sgn ? int'($signed(x)) : int'(x);
    end
    return s[OW-1:0];
  endfunction
  task automatic test_reset();
    rst_n = 0;
    #3;
    checks++; if (din_ready_u !== 1'b1) $display("FAIL reset_din_ready got=%b exp=1", din_ready_u);
    if (din_ready_u !== 1'b1) errors++;
    checks++; if (dout_valid_u !== 1'b0 || dout_u !== '0) begin errors++; $display("FAIL reset_out got v=%b d=%h exp v=0 d=000", dout_valid_u, dout_u); end
    @(negedge clk); @(negedge clk);
    rst_n = 1;
    #1;
    checks++; if (din_ready_u !== 1'b1) begin errors++; $display("FAIL post_reset_din_ready got=%b exp=1", din_ready_u); end
  endtask
  task automatic test_single_beat(input logic [W-1:0] lane, input logic [OW-1:0] exp_u, input logic [OW-1:0] exp_s);
    @(negedge clk);
    din_valid = 1; adder_din = {N{lane}}; dout_ready = 1;
    @(negedge clk);
    din_valid = 0;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) @(negedge clk);
      checks++;
      if (c < 3 && dout_valid_u !== 1'b0) begin errors++; $display("FAIL early_valid lane=%h cyc=%0d got=%b exp=0", lane, c, dout_valid_u); end
      if (c == 3 && (dout_valid_u !== 1'b1 || dout_u !== exp_u)) begin errors++; $display("FAIL unsigned_sum lane=%h got v=%b d=%h exp v=1 d=%h", lane, dout_valid_u, dout_u, exp_u); end
    end
    checks++; if (dout_valid_s !== 1'b1 || dout_s !== exp_s) begin errors++; $display("FAIL signed_sum lane=%h got v=%b d=%h exp v=1 d=%h", lane, dout_valid_s, dout_s, exp_s); end
    @(negedge clk);
    checks++; if (dout_valid_u !== 1'b0 || dout_u !== '0) begin errors++; $display("FAIL no_dup lane=%h got v=%b d=%h exp v=0 d=000", lane, dout_valid_u, dout_u); end
  endtask
  task automatic test_stall();
    int sent = 0, got = 0;
    bit prev_stall = 0;
    logic [OW-1:0] prev_u = '0;
    for (int c = 0; c < 80 && got < 8; c++) begin
      @(negedge clk);
      if (prev_stall) begin
        checks++;
        if (dout_valid_u !== 1'b1 || dout_u !== prev_u) begin errors++; $display("FAIL stall_hold cyc=%0d got v=%b d=%h exp v=1 d=%h", c, dout_valid_u, dout_u, prev_u); end
      end
      din_valid = sent < 8; adder_din = {N{8'(sent + 1)}}; dout_ready = !(c >= 5 && c < 10);
      #1;
      if (dout_valid_u && !dout_ready) begin
        checks++;
        if (din_ready_u !== 1'b0) begin errors++; $display("FAIL stall_din_ready cyc=%0d got=%b exp=0", c, din_ready_u); end
      end
      if (dout_valid_u && dout_ready) begin
        checks++;
        if (dout_u !== 12'(8 * (got + 1)) || dout_s !== 12'(8 * (got + 1))) begin errors++; $display("FAIL stall_order idx=%0d got u=%h s=%h exp=%h", got, dout_u, dout_s, 12'(8 * (got + 1))); end
        got++;
      end
      if (din_valid && din_ready_u) sent++;
      prev_stall = dout_valid_u && !dout_ready; prev_u = dout_u;
    end
    din_valid = 0; dout_ready = 1;
    checks++; if (got != 8) begin errors++; $display("FAIL stall_count got=%0d exp=8", got); end
  endtask
  task automatic test_reset_midflight();
    int bad = 0;
    dout_ready = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      din_valid = 1; adder_din = {N{8'h01}};
    end
    @(negedge clk);
    din_valid = 0;
    @(negedge clk);
    checks++; if (dout_valid_u !== 1'b1) begin errors++; $display("FAIL inflight_valid got=%b exp=1", dout_valid_u); end
    #2 rst_n = 0;
    #1;
    checks++; if (dout_valid_u !== 1'b0 || dout_u !== '0) begin errors++; $display("FAIL async_clear got v=%b d=%h exp v=0 d=000", dout_valid_u, dout_u); end
    checks++; if (din_ready_u !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", din_ready_u); end
    @(negedge clk);
    rst_n = 1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (dout_valid_u !== 1'b0 || dout_s !== '0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL stale_after_reset got=%0d stale cycles exp=0", bad); end
  endtask
  task automatic test_random();
    logic [OW-1:0] qu[$], qs[$];
    int sent = 0, got = 0;
    for (int c = 0; c < 60000 && got < 10000; c++) begin
      @(negedge clk);
      din_valid = sent < 10000 && $urandom_range(0, 3) != 0;
      adder_din = {$urandom, $urandom};
      dout_ready = $urandom_range(0, 3) != 0;
      #1;
      if (!dout_valid_u) begin
        checks++;
        if (dout_u !== '0) begin errors++; $display("FAIL idle_zero cyc=%0d got=%h exp=000", c, dout_u); end
      end else if (dout_ready) begin
        checks++;
        if (qu.size() == 0) begin errors++; $display("FAIL rand_extra cyc=%0d got=%h exp=none", c, dout_u); end
        else begin
          logic [OW-1:0] eu, es;
          eu = qu.pop_front(); es = qs.pop_front();
          if (dout_u !== eu || dout_s !== es) begin errors++; $display("FAIL rand_sum idx=%0d got u=%h s=%h exp u=%h s=%h", got, dout_u, dout_s, eu, es); end
        end
        got++;
      end
      if (din_valid && din_ready_u) begin
        qu.push_back(ref_sum(adder_din, 0)); qs.push_back(ref_sum(adder_din, 1)); sent++;
      end
    end
    din_valid = 0; dout_ready = 1;
    checks++; if (got != 10000) begin errors++; $display("FAIL rand_count got=%0d exp=10000", got); end
  endtask
`ifdef ADDER_TREE_ACC_EN
  task automatic test_acc();
    int cnt = 0;
    logic [OW-1:0] val = '0;
    dout_ready = 1;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      din_valid = c < 3; din_last = c == 2; adder_din = {N{8'h01}};
      if (dout_valid_u) begin cnt++; val = dout_u; end
    end
    din_valid = 0; din_last = 0;
    checks++; if (cnt != 1) begin errors++; $display("FAIL acc_count got=%0d exp=1", cnt); end
    checks++; if (val !== 12'h018) begin errors++; $display("FAIL acc_total got=%h exp=018", val); end
  endtask
`endif
  initial begin
    test_reset();
`ifdef ADDER_TREE_ACC_EN
    test_acc();
`else
    test_single_beat(8'hFF, 12'h7F8, 12'hFF8);
    test_single_beat(8'h80, 12'h400, 12'hC00);
    test_single_beat(8'h01, 12'h008, 12'h008);
    test_stall();
    test_reset_midflight();
    test_single_beat(8'h7F, 12'h3F8, 12'h3F8);
    test_random();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/adder_tree_stream.md
ADDER_TREE_STREAM -- requirements
Module: adder_tree_stream

Interface
REQ-001 Parameter LAYER_NUM, default 4: tree depth; lane count N = 2**(LAYER_NUM-1); legal range 2..7.
REQ-002 Parameter MIN_ADDER_WIDTH, default 8: width of each input lane, legal range 2..32.
REQ-003 Parameter SIGNED, default 0: 0 = lanes zero-extended, 1 = lanes two's-complement sign-extended.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 din_valid  input  1  adder_din carries a beat.
REQ-007 din_ready  output  1  block accepts a beat this cycle.
REQ-008 adder_din  input  N*MIN_ADDER_WIDTH  packed lanes; lane i = adder_din[i*MIN_ADDER_WIDTH +: MIN_ADDER_WIDTH].
REQ-009 dout_valid  output  1  adder_dout holds a result.
REQ-010 dout_ready  input  1  downstream accepts the result.
REQ-011 adder_dout  output  LAYER_NUM+MIN_ADDER_WIDTH  sum of all N lanes.
REQ-012 din_last  input  1  end-of-frame tag; present only when ADDER_TREE_ACC_EN is defined.

Function
REQ-013 Tree SHALL have LAYER_NUM-1 adder layers, each registered; layer k adds adjacent pairs of layer k-1 and widens by 1 bit.
REQ-014 Each layer SHALL carry a valid bit; a beat is accepted when din_valid && din_ready.
REQ-015 Global advance enable en = !dout_valid || dout_ready; all layers and valid bits SHALL update only when en is 1.
REQ-016 din_ready SHALL equal en (combinational from dout_ready and dout_valid); internal bubbles are not compressed during stall.
REQ-017 Latency SHALL be exactly LAYER_NUM-1 en-cycles: beat accepted at edge t with no stall appears with dout_valid=1 after edge t+LAYER_NUM-1.
REQ-018 Throughput SHALL be one beat per cycle while dout_ready=1.
REQ-019 Result SHALL be extended (per SIGNED) to LAYER_NUM+MIN_ADDER_WIDTH bits; no overflow is possible.
REQ-020 While dout_valid=1 and dout_ready=0, adder_dout and dout_valid SHALL hold stable.
REQ-021 Data registers of invalid stages SHALL still load on en (don't-care), but adder_dout SHALL be 0 whenever dout_valid=0.
REQ-022 Beats SHALL exit in acceptance order; none dropped or duplicated under any dout_ready pattern.

Reset
REQ-023 rst_n=0 SHALL asynchronously clear all valid bits, all data registers, dout_valid=0, adder_dout=0.
REQ-024 Reset mid-operation SHALL discard all in-flight beats and any partial accumulation; first beat after release has normal latency.
REQ-025 din_ready SHALL be 1 during and immediately after reset.

Configuration
REQ-026 Macro ADDER_TREE_ACC_EN, when defined, SHALL add din_last and an accumulate stage after the tree: din_last travels with its beat; tree sums add into an accumulator (modulo 2**(LAYER_NUM+MIN_ADDER_WIDTH)); dout_valid asserts only for a beat tagged last, presenting the frame total, and the accumulator restarts from 0 for the next beat; latency becomes LAYER_NUM en-cycles from the last beat.
REQ-027 Without ADDER_TREE_ACC_EN, din_last SHALL not exist and every accepted beat SHALL produce one result per REQ-017.

Verification (LAYER_NUM=4, MIN_ADDER_WIDTH=8, output 12 bits)
REQ-028 SIGNED=0, all lanes 8'hFF, dout_ready=1 -> adder_dout=12'h7F8, dout_valid 3 cycles after acceptance.
REQ-029 SIGNED=1, all lanes 8'hFF -> adder_dout=12'hFF8 (-8); lanes 8'h80 -> 12'hC00 (-1024).
REQ-030 Stream beats with lanes=1..8 consecutive cycles, dout_ready=0 for 5 cycles mid-stream -> din_ready=0, adder_dout held, all results (8, 16, 24, ...) emitted in order, none lost.
REQ-031 Assert rst_n=0 with 3 beats in flight -> dout_valid=0 and adder_dout=0 immediately; no stale result after release.
REQ-032 ADDER_TREE_ACC_EN defined, three beats of all lanes 8'h01, din_last on third -> single result 12'h018, no dout_valid on first two beats.
REQ-033 Random lanes, random din_valid/dout_ready, 10000 beats -> every result matches reference-model sum in order.
